// File: rtl/hot_tracker_query_ctrl.sv
// Query sequencer for the page hot tracker: counts snooped AXI address handshakes,
// issues MIG/FLUSH queries with a timeout guard, and buffers migration addresses for the host.
module hot_tracker_query_ctrl #(
    parameter int unsigned ADDR_SIZE  = 28,
    parameter int unsigned CNT_SIZE   = 32,
    parameter int unsigned CMD_WIDTH  = 4,
    parameter int unsigned MIG_TH     = 450,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                 afu_clk,
    input  logic                 afu_rst,
    input  logic                 enable,
    input  logic                 snoop_ar_fire,
    input  logic                 snoop_aw_fire,
    input  logic                 flush_req,
    output logic                 query_en,
    output logic [CMD_WIDTH-1:0] query_cmd,
    input  logic                 query_ready,
    input  logic                 trk_mig_addr_en,
    input  logic [ADDR_SIZE-1:0] trk_mig_addr,
    output logic                 trk_mig_addr_ready,
    output logic                 host_mig_addr_valid,
    output logic [ADDR_SIZE-1:0] host_mig_addr,
    input  logic                 host_mig_addr_ready,
    output logic [CNT_SIZE-1:0]  access_cnt,
    output logic [CNT_SIZE-1:0]  query_cnt,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned EPOCH_W   = $clog2(2 * MIG_TH);
    localparam int unsigned EPOCH_MAX = 2 * MIG_TH - 1;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned FILL_W    = PTR_W + 1;
    localparam int unsigned WAIT_W    = $clog2(TIMEOUT + 1);

    localparam logic [CMD_WIDTH-1:0] CMD_IDLE  = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CMD_MIG   = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_FLUSH = CMD_WIDTH'(2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUERY,
        ST_RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;
    logic [EPOCH_W:0]     epoch_sum;
    logic                 flush_pend_q, flush_pend_d;
    logic [CMD_WIDTH-1:0] cmd_d;
    logic                 query_en_d, busy_d, timeout_err_d;
    logic [CNT_SIZE-1:0]  access_cnt_d, query_cnt_d;
    logic [CNT_SIZE:0]    access_sum;
    logic [1:0]           inc;
    logic                 issue_mig, issue_flush, q_done, q_tmo;

    logic [ADDR_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 push, pop;
    logic                 tready_d, hvalid_d;
    logic [ADDR_SIZE-1:0] head_d;

    // Query sequencer: next state and next registered command outputs
    always_comb begin
        state_d     = state_q;
        cmd_d       = query_cmd;
        wait_d      = wait_q;
        issue_mig   = 1'b0;
        issue_flush = 1'b0;
        q_done      = 1'b0;
        q_tmo       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                cmd_d  = CMD_IDLE;
                if (flush_pend_q) begin
                    state_d     = ST_QUERY;
                    cmd_d       = CMD_FLUSH;
                    issue_flush = 1'b1;
                end else if (enable && (epoch_q >= EPOCH_W'(MIG_TH))) begin
                    state_d   = ST_QUERY;
                    cmd_d     = CMD_MIG;
                    issue_mig = 1'b1;
                end
            end
            ST_QUERY: begin
                if (query_ready) begin
                    state_d = ST_RELEASE;
                    cmd_d   = CMD_IDLE;
                    q_done  = 1'b1;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = ST_RELEASE;
                    cmd_d   = CMD_IDLE;
                    q_tmo   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_IDLE;
            end
        endcase
        query_en_d = (state_d == ST_QUERY);
        busy_d     = (state_d != ST_IDLE);
    end

    // Access accounting; epoch keeps at most one pending epoch beyond the current one
    always_comb begin
        inc        = enable ? (2'(snoop_ar_fire) + 2'(snoop_aw_fire)) : 2'd0;
        epoch_sum  = (EPOCH_W + 1)'(epoch_q) + (EPOCH_W + 1)'(inc)
                   - (issue_mig ? (EPOCH_W + 1)'(MIG_TH) : '0);
        epoch_d    = (epoch_sum > (EPOCH_W + 1)'(EPOCH_MAX)) ? EPOCH_W'(EPOCH_MAX)
                                                             : epoch_sum[EPOCH_W-1:0];
        access_sum   = (CNT_SIZE + 1)'(access_cnt) + (CNT_SIZE + 1)'(inc);
        access_cnt_d = access_sum[CNT_SIZE] ? '1 : access_sum[CNT_SIZE-1:0];
        query_cnt_d  = (q_done && (query_cnt != '1)) ? query_cnt + CNT_SIZE'(1) : query_cnt;
        flush_pend_d  = (flush_pend_q & ~issue_flush) | flush_req;
        timeout_err_d = timeout_err | q_tmo;
    end

    // Migration FIFO bookkeeping; head is registered so it must look through a same-cycle write
    always_comb begin
        push     = trk_mig_addr_en & trk_mig_addr_ready;
        pop      = host_mig_addr_valid & host_mig_addr_ready;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fill_d   = fill_q + FILL_W'(push) - FILL_W'(pop);
        tready_d = (fill_d != FILL_W'(FIFO_DEPTH));
        hvalid_d = (fill_d != '0);
        if (fill_d == '0) begin
            head_d = '0;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = trk_mig_addr;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge afu_clk) begin
        if (afu_rst) begin
            state_q             <= ST_IDLE;
            wait_q              <= '0;
            epoch_q             <= '0;
            flush_pend_q        <= 1'b0;
            query_en            <= 1'b0;
            query_cmd           <= CMD_IDLE;
            busy                <= 1'b0;
            timeout_err         <= 1'b0;
            access_cnt          <= '0;
            query_cnt           <= '0;
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            fill_q              <= '0;
            trk_mig_addr_ready  <= 1'b1;
            host_mig_addr_valid <= 1'b0;
            host_mig_addr       <= '0;
        end else begin
            state_q             <= state_d;
            wait_q              <= wait_d;
            epoch_q             <= epoch_d;
            flush_pend_q        <= flush_pend_d;
            query_en            <= query_en_d;
            query_cmd           <= cmd_d;
            busy                <= busy_d;
            timeout_err         <= timeout_err_d;
            access_cnt          <= access_cnt_d;
            query_cnt           <= query_cnt_d;
            wr_ptr_q            <= wr_ptr_d;
            rd_ptr_q            <= rd_ptr_d;
            fill_q              <= fill_d;
            trk_mig_addr_ready  <= tready_d;
            host_mig_addr_valid <= hvalid_d;
            host_mig_addr       <= head_d;
        end
    end

    // Storage array carries no reset; pointer reset discards contents
    always_ff @(posedge afu_clk) begin
        if (!afu_rst && push) begin
            mem[wr_ptr_q] <= trk_mig_addr;
        end
    end

endmodule

// File: tb/tb_hot_tracker_query_ctrl.sv
// Randomized scoreboard bench for hot_tracker_query_ctrl against a behavioural model.
module tb_hot_tracker_query_ctrl;

    localparam int unsigned ADDR_SIZE  = 28;
    localparam int unsigned CNT_SIZE   = 32;
    localparam int unsigned CMD_WIDTH  = 4;
    localparam int unsigned MIG_TH     = 4;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned TIMEOUT    = 16;

    logic                 afu_clk = 1'b0;
    logic                 afu_rst;
    logic                 enable;
    logic                 snoop_ar_fire;
    logic                 snoop_aw_fire;
    logic                 flush_req;
    logic                 query_en;
    logic [CMD_WIDTH-1:0] query_cmd;
    logic                 query_ready;
    logic                 trk_mig_addr_en;
    logic [ADDR_SIZE-1:0] trk_mig_addr;
    logic                 trk_mig_addr_ready;
    logic                 host_mig_addr_valid;
    logic [ADDR_SIZE-1:0] host_mig_addr;
    logic                 host_mig_addr_ready;
    logic [CNT_SIZE-1:0]  access_cnt;
    logic [CNT_SIZE-1:0]  query_cnt;
    logic                 busy;
    logic                 timeout_err;

    hot_tracker_query_ctrl #(
        .ADDR_SIZE(ADDR_SIZE), .CNT_SIZE(CNT_SIZE), .CMD_WIDTH(CMD_WIDTH),
        .MIG_TH(MIG_TH), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .afu_clk(afu_clk), .afu_rst(afu_rst), .enable(enable),
        .snoop_ar_fire(snoop_ar_fire), .snoop_aw_fire(snoop_aw_fire),
        .flush_req(flush_req), .query_en(query_en), .query_cmd(query_cmd),
        .query_ready(query_ready), .trk_mig_addr_en(trk_mig_addr_en),
        .trk_mig_addr(trk_mig_addr), .trk_mig_addr_ready(trk_mig_addr_ready),
        .host_mig_addr_valid(host_mig_addr_valid), .host_mig_addr(host_mig_addr),
        .host_mig_addr_ready(host_mig_addr_ready), .access_cnt(access_cnt),
        .query_cnt(query_cnt), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 afu_clk = ~afu_clk;

    typedef struct {
        bit              qen;
        int unsigned     cmd;
        bit              tready;
        bit              hvalid;
        bit              chk_addr;
        logic [27:0]     haddr;
        longint unsigned acc;
        longint unsigned qcnt;
        bit              busy;
        bit              terr;
    } snap_t;

    snap_t exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    // Reference model: "mode" 0 idle, 1 waiting on tracker, 2 release gap
    int              m_epoch, m_mode, m_cmd, m_wait;
    bit              m_pend, m_terr;
    longint unsigned m_acc, m_qcnt;
    logic [27:0]     m_fifo[$];

    always @(posedge afu_clk) begin
        snap_t s;
        int    inc;
        bit    do_push, do_pop, took_mig;
        if (afu_rst) begin
            m_epoch = 0; m_mode = 0; m_cmd = 0; m_wait = 0;
            m_pend = 0; m_terr = 0; m_acc = 0; m_qcnt = 0;
            m_fifo.delete();
        end else begin
            inc      = enable ? (int'(snoop_ar_fire) + int'(snoop_aw_fire)) : 0;
            m_acc    = (m_acc + inc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_acc + inc;
            do_pop   = host_mig_addr_ready && (m_fifo.size() > 0);
            do_push  = trk_mig_addr_en && (m_fifo.size() < FIFO_DEPTH);
            if (do_pop) void'(m_fifo.pop_front());
            if (do_push) m_fifo.push_back(trk_mig_addr);
            took_mig = 0;
            if (m_mode == 0) begin
                if (m_pend) begin
                    m_mode = 1; m_cmd = 2; m_wait = 0; m_pend = 0;
                end else if (enable && m_epoch >= MIG_TH) begin
                    m_mode = 1; m_cmd = 1; m_wait = 0; took_mig = 1;
                end
            end else if (m_mode == 1) begin
                m_wait++;
                if (query_ready) begin
                    m_mode = 2; m_qcnt++;
                end else if (m_wait == TIMEOUT) begin
                    m_mode = 2; m_terr = 1;
                end
            end else begin
                m_mode = 0;
            end
            if (flush_req) m_pend = 1;
            m_epoch = m_epoch + inc - (took_mig ? MIG_TH : 0);
            if (m_epoch > 2 * MIG_TH - 1) m_epoch = 2 * MIG_TH - 1;
        end
        s.qen      = (m_mode == 1);
        s.cmd      = (m_mode == 1) ? m_cmd : 0;
        s.busy     = (m_mode != 0);
        s.tready   = (m_fifo.size() < FIFO_DEPTH);
        s.hvalid   = (m_fifo.size() > 0);
        s.chk_addr = afu_rst || (m_fifo.size() > 0);
        s.haddr    = (m_fifo.size() > 0) ? m_fifo[0] : 28'h0;
        s.acc      = m_acc;
        s.qcnt     = m_qcnt;
        s.terr     = m_terr;
        exp_q.push_back(s);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: compares every registered output against the model's expectation
    always @(negedge afu_clk) begin
        snap_t s;
        if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            chk("query_en", 64'(query_en), 64'(s.qen));
            chk("query_cmd", 64'(query_cmd), 64'(s.cmd));
            chk("busy", 64'(busy), 64'(s.busy));
            chk("trk_mig_addr_ready", 64'(trk_mig_addr_ready), 64'(s.tready));
            chk("host_mig_addr_valid", 64'(host_mig_addr_valid), 64'(s.hvalid));
            if (s.chk_addr) chk("host_mig_addr", 64'(host_mig_addr), 64'(s.haddr));
            chk("access_cnt", 64'(access_cnt), s.acc);
            chk("query_cnt", 64'(query_cnt), s.qcnt);
            chk("timeout_err", 64'(timeout_err), 64'(s.terr));
        end
    end

    int rdy_mode = 1;

    task automatic tick();
        case (rdy_mode)
            0:       query_ready = 1'b0;
            1:       query_ready = 1'b1;
            default: query_ready = ($urandom_range(0, 2) == 0);
        endcase
        @(posedge afu_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    initial begin
        afu_rst = 1'b1; enable = 1'b0; snoop_ar_fire = 1'b0; snoop_aw_fire = 1'b0;
        flush_req = 1'b0; query_ready = 1'b0; trk_mig_addr_en = 1'b0;
        trk_mig_addr = '0; host_mig_addr_ready = 1'b0;
        ticks(2);
        afu_rst = 1'b0;
        ticks(2);

        // Four single reads trigger exactly one MIG query
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            snoop_ar_fire = 1'b1; tick();
            snoop_ar_fire = 1'b0; tick();
        end
        ticks(8);

        // Three cycles of simultaneous read+write: six accesses, remainder carried
        snoop_ar_fire = 1'b1; snoop_aw_fire = 1'b1;
        ticks(3);
        snoop_ar_fire = 1'b0; snoop_aw_fire = 1'b0;
        ticks(8);

        // Flush arriving during a pending MIG query is issued afterwards
        rdy_mode = 0;
        snoop_ar_fire = 1'b1; ticks(2); snoop_ar_fire = 1'b0;
        ticks(3);
        pulse_flush();
        ticks(3);
        rdy_mode = 1;
        ticks(10);

        // Timeout with accesses saturating the epoch counter meanwhile
        rdy_mode = 0;
        pulse_flush();
        snoop_ar_fire = 1'b1; snoop_aw_fire = 1'b1;
        ticks(22);
        snoop_ar_fire = 1'b0; snoop_aw_fire = 1'b0;
        rdy_mode = 1;
        ticks(15);

        // Fill FIFO beyond depth, then drain in order
        for (int i = 1; i <= 17; i++) begin
            trk_mig_addr_en = 1'b1;
            trk_mig_addr    = 28'h1000000 + 28'(i);
            tick();
        end
        tick();
        host_mig_addr_ready = 1'b1;
        tick();
        trk_mig_addr_en = 1'b0;
        ticks(20);
        host_mig_addr_ready = 1'b0;

        // Reset in the middle of a query with two FIFO entries
        trk_mig_addr_en = 1'b1; trk_mig_addr = 28'h0ABCDE1; tick();
        trk_mig_addr = 28'h0ABCDE2; tick();
        trk_mig_addr_en = 1'b0;
        rdy_mode = 0;
        pulse_flush();
        ticks(3);
        afu_rst = 1'b1; tick(); afu_rst = 1'b0;
        rdy_mode = 1;
        ticks(5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) rdy_mode = ($urandom_range(0, 4) == 0) ? 0 : 2;
            enable              = ($urandom_range(0, 7) != 0);
            snoop_ar_fire       = $urandom_range(0, 1) == 1;
            snoop_aw_fire       = $urandom_range(0, 1) == 1;
            flush_req           = ($urandom_range(0, 19) == 0);
            trk_mig_addr_en     = $urandom_range(0, 1) == 1;
            trk_mig_addr        = 28'($urandom);
            host_mig_addr_ready = ($urandom_range(0, 4) < 2);
            afu_rst             = ($urandom_range(0, 599) == 0);
            tick();
        end
        afu_rst = 1'b0; enable = 1'b0; flush_req = 1'b0;
        trk_mig_addr_en = 1'b0; host_mig_addr_ready = 1'b0;
        snoop_ar_fire = 1'b0; snoop_aw_fire = 1'b0;
        rdy_mode = 1;
        ticks(4);
        @(negedge afu_clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
